// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its program loader front end.
package cpu_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } ld_state_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

endpackage

// File: rtl/program_ram.sv
// DEPTH x DW program store: synchronous write, asynchronous read, cleared on reset.
module program_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Loads a host program into program RAM while holding the CPU in Load,
// then serves instruction bytes addressed by the CPU program counter.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_load,
    input  logic [DW-1:0] host_data,
    input  logic          host_valid,
    input  logic          host_last,
    output logic          host_ready,
    input  logic [AW-1:0] pc_in,
    output logic [DW-1:0] cpu_instr,
    output logic          cpu_load,
    output logic [AW:0]   prog_len,
    output logic          overflow,
    output logic          halted
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    ld_state_e   state_q, state_d;
    // The write pointer doubles as the program length: every accepted byte advances both.
    logic [AW:0] wptr_q, wptr_d;
    logic        ovf_q, ovf_d;
    logic        flush_q, flush_d;
    logic [1:0]  hcnt_q, hcnt_d;

    logic          hs;
    logic [DW-1:0] ram_rdata;

    assign host_ready = (state_q == ST_LOAD) && !start_load && (wptr_q < DEPTH_W);
    assign hs         = host_valid && host_ready;

    program_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we_i    (hs),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (host_data),
        .raddr_i (pc_in),
        .rdata_o (ram_rdata)
    );

    // Addresses past the loaded program read as HLT so stale RAM is never executed.
    assign cpu_instr = ({1'b0, pc_in} < wptr_q) ? ram_rdata : '0;
    assign cpu_load  = (state_q != ST_RUN);
    assign prog_len  = wptr_q;
    assign overflow  = ovf_q;
    assign halted    = (state_q == ST_RUN) && (hcnt_q == 2'd2);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        ovf_d   = ovf_q;
        flush_d = flush_q;
        hcnt_d  = 2'd0;

        if (state_q == ST_RUN && cpu_instr[DW-1:DW-3] == OP_HLT) begin
            hcnt_d = (hcnt_q == 2'd3) ? 2'd3 : hcnt_q + 2'd1;
        end

        if (start_load) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            ovf_d   = 1'b0;
            flush_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (hs) begin
                        wptr_d = wptr_q + 1'b1;
                        if (host_last) begin
                            state_d = ST_FLUSH;
                        end else if (wptr_q == DEPTH_W - 1'b1) begin
                            ovf_d   = 1'b1;
                            state_d = ST_FLUSH;
                        end
                    end
                end
                // Two Load-high cycles so the CPU sees a clean Load falling edge with PC=0.
                ST_FLUSH: begin
                    flush_d = ~flush_q;
                    if (flush_q) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
            flush_q <= 1'b0;
            hcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
            flush_q <= flush_d;
            hcnt_q  <= hcnt_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_load = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_valid = 1'b0;
    logic       host_last = 1'b0;
    logic [4:0] pc_in = 5'd0;
    logic       host_ready;
    logic [7:0] cpu_instr;
    logic       cpu_load;
    logic [5:0] prog_len;
    logic       overflow;
    logic       halted;

    int checks = 0;
    int errors = 0;

    program_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start_load (start_load),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_last  (host_last),
        .host_ready (host_ready),
        .pc_in      (pc_in),
        .cpu_instr  (cpu_instr),
        .cpu_load   (cpu_load),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 loading, 2 flushing, 3 running.
    int         m_phase = 0;
    int         m_len = 0;
    bit         m_ovf = 0;
    int         m_fl = 0;
    int         m_hc = 0;
    logic [7:0] m_mem [32];
    logic [7:0] m_cur;
    bit         m_hs;

    function automatic logic [7:0] m_instr();
        return (int'(pc_in) < m_len) ? m_mem[pc_in] : 8'h00;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_len = 0; m_ovf = 0; m_fl = 0; m_hc = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        end else begin
            m_cur = m_instr();
            m_hs  = (m_phase == 1) && !start_load && (m_len < 32) && host_valid;
            if (m_phase == 3) m_hc = (m_cur[7:5] == 3'b000) ? ((m_hc < 3) ? m_hc + 1 : 3) : 0;
            else m_hc = 0;
            if (start_load) begin
                m_phase = 1; m_len = 0; m_ovf = 0;
            end else if (m_phase == 1 && m_hs) begin
                m_mem[m_len] = host_data;
                m_len++;
                if (host_last) begin
                    m_phase = 2; m_fl = 2;
                end else if (m_len == 32) begin
                    m_ovf = 1; m_phase = 2; m_fl = 2;
                end
            end else if (m_phase == 2) begin
                m_fl--;
                if (m_fl == 0) m_phase = 3;
            end
        end
    end

    always @(negedge clock) begin
        chk("cpu_load",   cpu_load,   m_phase != 3);
        chk("host_ready", host_ready, (m_phase == 1) && !start_load && (m_len < 32));
        chk("cpu_instr",  cpu_instr,  m_instr());
        chk("prog_len",   prog_len,   m_len);
        chk("overflow",   overflow,   m_ovf);
        chk("halted",     halted,     (m_phase == 3) && (m_hc == 2));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        cyc();
        start_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit ok;
        ok = 0;
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (host_ready) begin
                ok = 1;
                break;
            end
            cyc();
        end
        cyc();
        host_valid = 1'b0;
        host_last  = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    logic [7:0] prog_a [4];
    logic [7:0] sweep_exp [6];
    logic       halt_exp [3];
    bit         ran;

    initial begin
        prog_a    = '{8'hA1, 8'h5B, 8'hC2, 8'h00};
        sweep_exp = '{8'hA1, 8'h5B, 8'hC2, 8'h00, 8'h00, 8'h00};
        halt_exp  = '{1'b0, 1'b0, 1'b1};

        repeat (2) cyc();
        reset = 1'b1;
        repeat (5) cyc();
        @(negedge clock);
        chk("idle_cpu_load", cpu_load, 1);
        chk("idle_instr", cpu_instr, 8'h00);
        chk("idle_ready", host_ready, 0);
        chk("idle_len", prog_len, 0);
        cyc();

        // Four-byte program, Load release timing, pc sweep.
        pulse_start();
        for (int i = 0; i < 4; i++) send(prog_a[i], i == 3);
        @(negedge clock); chk("flush0_load", cpu_load, 1);
        cyc();
        @(negedge clock); chk("flush1_load", cpu_load, 1);
        cyc();
        @(negedge clock); chk("run_load", cpu_load, 0);
        chk("run_len", prog_len, 4);
        cyc();
        for (int p = 0; p < 6; p++) begin
            pc_in = 5'(p);
            @(negedge clock); chk("sweep_instr", cpu_instr, sweep_exp[p]);
            cyc();
        end

        // Halt detection.
        pc_in = 5'd0;
        cyc();
        pc_in = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); chk("halt_seq", halted, halt_exp[i]);
            cyc();
        end
        pc_in = 5'd0;
        cyc();
        @(negedge clock); chk("halt_clear", halted, 0);
        cyc();

        // Overflow: 33 bytes without last.
        pulse_start();
        for (int i = 0; i < 32; i++) send(8'(i * 7 + 3), 1'b0);
        @(negedge clock);
        chk("ovf_ready", host_ready, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_len", prog_len, 32);
        host_valid = 1'b1; host_data = 8'hEE;
        ran = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            @(negedge clock);
            if (!cpu_load) begin ran = 1; break; end
        end
        chk("ovf_run", ran, 1);
        chk("ovf_len_run", prog_len, 32);
        cyc();
        host_valid = 1'b0;

        // start_load beats a same-cycle handshake.
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 1'b0);
        host_valid = 1'b1; host_data = 8'hFF; start_load = 1'b1;
        @(negedge clock); chk("prio_ready", host_ready, 0);
        cyc();
        start_load = 1'b0; host_valid = 1'b0;
        @(negedge clock); chk("prio_len", prog_len, 0);
        cyc();
        send(8'h77, 1'b1);
        pc_in = 5'd0;
        @(negedge clock);
        chk("prio_addr0", cpu_instr, 8'h77);
        chk("prio_len1", prog_len, 1);
        cyc();

        // Reset mid-load.
        pulse_start();
        send(8'h9A, 1'b0);
        send(8'hBC, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_load", cpu_load, 1);
        chk("rst_len", prog_len, 0);
        chk("rst_ready", host_ready, 0);
        cyc();
        reset = 1'b1;
        cyc();
        pulse_start();
        send(8'h3C, 1'b0);
        send(8'h00, 1'b1);
        pc_in = 5'd1;
        @(negedge clock); chk("rst_reload", cpu_instr, 8'h00);
        cyc();

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 4000; n++) begin
            start_load = ($urandom_range(0, 39) == 0);
            host_valid = ($urandom_range(0, 3) != 0);
            host_data  = 8'($urandom);
            host_last  = ($urandom_range(0, 11) == 0);
            pc_in      = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
            cyc();
        end
        start_load = 1'b0; host_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
